// File: rtl/alu_regfile_if.sv
// Bus between the decode/sequencing logic (master) and the alu_regfile
// datapath core (slave). It carries addresses, opcode, immediate and write-back.
interface alu_regfile_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int IMM_W  = 8
);
  logic        [ADDR_W-1:0] address_a;
  logic        [ADDR_W-1:0] address_b;
  logic                     write_enable;
  logic signed [DATA_W-1:0] write_data;
  logic        [3:0]        opcode;
  logic signed [IMM_W-1:0]  immediate;
  logic signed [DATA_W-1:0] data_a;
  logic signed [DATA_W-1:0] data_b;
  logic signed [DATA_W-1:0] alu_result;
  logic                     zero;
  logic                     overflow;

  modport master (
    output address_a, address_b, write_enable, write_data, opcode, immediate,
    input  data_a, data_b, alu_result, zero, overflow
  );

  modport slave (
    input  address_a, address_b, write_enable, write_data, opcode, immediate,
    output data_a, data_b, alu_result, zero, overflow
  );
endinterface

// File: rtl/alu_regfile.sv
// Datapath core of the 16-bit toy processor: 8-entry 2R/1W register file and a
// combinational signed ALU. Define ALU_RF_BYPASS_EN to forward write_data to reads.
module alu_regfile #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int IMM_W  = 8
) (
  input  logic          clk,
  input  logic          reset,
  alu_regfile_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [3:0] {
    OP_LOAD = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0011,
    OP_JMP  = 4'b1000,
    OP_ADDI = 4'b1010,
    OP_SUBI = 4'b1011,
    OP_BR   = 4'b1100,
    OP_MOV  = 4'b1110,
    OP_OUT  = 4'b1111
  } opcode_e;

  function automatic logic signed [DATA_W-1:0] sext_imm(input logic signed [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

  function automatic logic add_ovf(input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b,
                                   input logic signed [DATA_W-1:0] r);
    return (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
  endfunction

  // a - b overflows when the operands differ in sign and the result takes b's sign.
  function automatic logic sub_ovf(input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b,
                                   input logic signed [DATA_W-1:0] r);
    return (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
  endfunction

  logic signed [DATA_W-1:0] regs [DEPTH];
  logic signed [DATA_W-1:0] rd_a;
  logic signed [DATA_W-1:0] rd_b;
  logic signed [DATA_W-1:0] imm_s;
  logic signed [DATA_W-1:0] sum_ab;
  logic signed [DATA_W-1:0] dif_ab;
  logic signed [DATA_W-1:0] sum_ai;
  logic signed [DATA_W-1:0] dif_ai;
  logic signed [DATA_W-1:0] alu_res;
  logic                     alu_ovf;

  // Register array write port; reset wins over a concurrent write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.write_enable) begin
      regs[bus.address_a] <= bus.write_data;
    end
  end

`ifdef ALU_RF_BYPASS_EN
  logic fwd_en;
  assign fwd_en = bus.write_enable && !reset;
  // Port A always addresses the write target, so it forwards whenever a write is live.
  assign rd_a = fwd_en ? bus.write_data : regs[bus.address_a];
  assign rd_b = (fwd_en && (bus.address_b == bus.address_a)) ? bus.write_data
                                                               : regs[bus.address_b];
`else
  assign rd_a = regs[bus.address_a];
  assign rd_b = regs[bus.address_b];
`endif

  assign imm_s  = sext_imm(bus.immediate);
  assign sum_ab = rd_a + rd_b;
  assign dif_ab = rd_a - rd_b;
  assign sum_ai = rd_a + imm_s;
  assign dif_ai = rd_a - imm_s;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.opcode)
      OP_LOAD: alu_res = imm_s;
      OP_ADD: begin
        alu_res = sum_ab;
        alu_ovf = add_ovf(rd_a, rd_b, sum_ab);
      end
      OP_ADDI: begin
        alu_res = sum_ai;
        alu_ovf = add_ovf(rd_a, imm_s, sum_ai);
      end
      OP_SUB: begin
        alu_res = dif_ab;
        alu_ovf = sub_ovf(rd_a, rd_b, dif_ab);
      end
      OP_SUBI: begin
        alu_res = dif_ai;
        alu_ovf = sub_ovf(rd_a, imm_s, dif_ai);
      end
      OP_MOV:  alu_res = rd_b;
      default: alu_res = '0;
    endcase
  end

  assign bus.data_a     = rd_a;
  assign bus.data_b     = rd_b;
  assign bus.alu_result = alu_res;
  assign bus.zero       = (alu_res == '0);
  assign bus.overflow   = alu_ovf;

endmodule

// File: tb/tb_alu_regfile.sv
// Scoreboard bench for alu_regfile: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares against the live outputs.
module tb_alu_regfile;

  logic clk = 1'b0;
  logic reset = 1'b1;

  alu_regfile_if #(.DATA_W(16), .ADDR_W(3), .IMM_W(8)) bus ();

  alu_regfile #(.DATA_W(16), .ADDR_W(3), .IMM_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] da;
    logic [15:0] db;
    logic [15:0] res;
    logic        z;
    logic        o;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Monitor: the combinational outputs are settled by the falling edge.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (bus.data_a !== e.da || bus.data_b !== e.db || bus.alu_result !== e.res ||
          bus.zero !== e.z || bus.overflow !== e.o) begin
        n_fail++;
        $display("FAIL %s: got a=%h b=%h r=%h z=%b o=%b, want a=%h b=%h r=%h z=%b o=%b",
                 e.name, bus.data_a, bus.data_b, bus.alu_result, bus.zero, bus.overflow,
                 e.da, e.db, e.res, e.z, e.o);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [15:0] val);
    bus.address_a    = addr;
    bus.write_data   = val;
    bus.write_enable = 1'b1;
    step();
    bus.write_enable = 1'b0;
  endtask

  // Drive one vector for a cycle and queue its expectation; a write, if
  // requested, lands at the end of the cycle.
  task automatic chk(input string name, input logic [2:0] aa, input logic [2:0] ab,
                     input logic [3:0] op, input logic [7:0] imm,
                     input logic we, input logic [15:0] wd,
                     input logic [15:0] da, input logic [15:0] db,
                     input logic [15:0] res, input logic z, input logic o);
    exp_t e;
    bus.address_a    = aa;
    bus.address_b    = ab;
    bus.opcode       = op;
    bus.immediate    = imm;
    bus.write_enable = we;
    bus.write_data   = wd;
    e.name = name; e.da = da; e.db = db; e.res = res; e.z = z; e.o = o;
    sb.push_back(e);
    step();
    bus.write_enable = 1'b0;
  endtask

  initial begin
    bus.address_a    = '0;
    bus.address_b    = '0;
    bus.write_enable = 1'b0;
    bus.write_data   = '0;
    bus.opcode       = '0;
    bus.immediate    = '0;
    step();
    step();
    reset = 1'b0;

    for (int i = 0; i < 8; i++) wr(3'(i), 16'h1111 * 16'(i + 1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++)
      chk($sformatf("reset_r%0d", i), 3'(i), 3'(7 - i), 4'b0010, 8'h00, 1'b0, 16'h0,
          16'h0, 16'h0, 16'h0, 1'b1, 1'b0);

    wr(3'd1, 16'h0005);
    wr(3'd2, 16'h0003);
    chk("add",        3'd1, 3'd2, 4'b0010, 8'h00, 1'b0, 16'h0, 16'h0005, 16'h0003, 16'h0008, 1'b0, 1'b0);
    chk("sub",        3'd1, 3'd2, 4'b0011, 8'h00, 1'b0, 16'h0, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0);
    chk("sub_neg",    3'd2, 3'd1, 4'b0011, 8'h00, 1'b0, 16'h0, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0);
    chk("subi_zero",  3'd1, 3'd2, 4'b1011, 8'h05, 1'b0, 16'h0, 16'h0005, 16'h0003, 16'h0000, 1'b1, 1'b0);
    chk("addi_neg",   3'd1, 3'd2, 4'b1010, 8'hFF, 1'b0, 16'h0, 16'h0005, 16'h0003, 16'h0004, 1'b0, 1'b0);

    wr(3'd3, 16'h7FFF);
    wr(3'd4, 16'h0001);
    wr(3'd5, 16'h8000);
    chk("add_ovf",    3'd3, 3'd4, 4'b0010, 8'h00, 1'b0, 16'h0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    chk("load_neg",   3'd3, 3'd4, 4'b0001, 8'h80, 1'b0, 16'h0, 16'h7FFF, 16'h0001, 16'hFF80, 1'b0, 1'b0);
    chk("sub_ovf",    3'd5, 3'd4, 4'b0011, 8'h00, 1'b0, 16'h0, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
    chk("subi_ovf",   3'd3, 3'd4, 4'b1011, 8'hFF, 1'b0, 16'h0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    chk("addi_pos",   3'd4, 3'd4, 4'b1010, 8'h7F, 1'b0, 16'h0, 16'h0001, 16'h0001, 16'h0080, 1'b0, 1'b0);

    chk("mov",        3'd1, 3'd2, 4'b1110, 8'h00, 1'b0, 16'h0, 16'h0005, 16'h0003, 16'h0003, 1'b0, 1'b0);
    chk("jmp",        3'd1, 3'd2, 4'b1000, 8'h00, 1'b0, 16'h0, 16'h0005, 16'h0003, 16'h0000, 1'b1, 1'b0);
    chk("out",        3'd3, 3'd4, 4'b1111, 8'h00, 1'b0, 16'h0, 16'h7FFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    chk("undef_op",   3'd3, 3'd4, 4'b0101, 8'h12, 1'b0, 16'h0, 16'h7FFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    chk("load_zero",  3'd1, 3'd2, 4'b0001, 8'h00, 1'b0, 16'h0, 16'h0005, 16'h0003, 16'h0000, 1'b1, 1'b0);

`ifdef ALU_RF_BYPASS_EN
    chk("wr_rd_same", 3'd1, 3'd1, 4'b1110, 8'h00, 1'b1, 16'h00AA, 16'h00AA, 16'h00AA, 16'h00AA, 1'b0, 1'b0);
`else
    chk("wr_rd_same", 3'd1, 3'd1, 4'b1110, 8'h00, 1'b1, 16'h00AA, 16'h0005, 16'h0005, 16'h0005, 1'b0, 1'b0);
`endif
    chk("after_wr",   3'd1, 3'd2, 4'b0010, 8'h00, 1'b0, 16'h0, 16'h00AA, 16'h0003, 16'h00AD, 1'b0, 1'b0);
`ifdef ALU_RF_BYPASS_EN
    chk("wr_rd_b_oth",3'd2, 3'd1, 4'b0010, 8'h00, 1'b1, 16'h0010, 16'h0010, 16'h00AA, 16'h00BA, 1'b0, 1'b0);
`else
    chk("wr_rd_b_oth",3'd2, 3'd1, 4'b0010, 8'h00, 1'b1, 16'h0010, 16'h0003, 16'h00AA, 16'h00AD, 1'b0, 1'b0);
`endif
    chk("after_wr2",  3'd2, 3'd1, 4'b0010, 8'h00, 1'b0, 16'h0, 16'h0010, 16'h00AA, 16'h00BA, 1'b0, 1'b0);

    bus.address_a    = 3'd6;
    bus.write_data   = 16'h1234;
    bus.write_enable = 1'b1;
    reset            = 1'b1;
    step();
    reset            = 1'b0;
    bus.write_enable = 1'b0;
    chk("rst_beats_we", 3'd6, 3'd6, 4'b0010, 8'h00, 1'b0, 16'h0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
    chk("rst_clr_r1",   3'd1, 3'd3, 4'b0011, 8'h00, 1'b0, 16'h0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);

    for (int i = 0; i < 4 && sb.size() != 0; i++) step();
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, want finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
